// File: rtl/ttt_pkg.sv
// Shared definitions for the tic-tac-toe automated player: cell/winner codes,
// FSM state type and the line/corner/edge lookup tables.
package ttt_pkg;

    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_X     = 2'b01;
    localparam logic [1:0] CELL_O     = 2'b10;
    localparam logic [1:0] CELL_BAD   = 2'b11;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_X    = 2'b01;
    localparam logic [1:0] WIN_O    = 2'b10;
    localparam logic [1:0] WIN_DRAW = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DECIDE,
        WAIT_ACK
    } state_e;

    localparam logic [3:0] LINES [8][3] = '{
        '{4'd0, 4'd1, 4'd2},
        '{4'd3, 4'd4, 4'd5},
        '{4'd6, 4'd7, 4'd8},
        '{4'd0, 4'd3, 4'd6},
        '{4'd1, 4'd4, 4'd7},
        '{4'd2, 4'd5, 4'd8},
        '{4'd0, 4'd4, 4'd8},
        '{4'd2, 4'd4, 4'd6}
    };

    localparam logic [3:0] CORNERS [4] = '{4'd0, 4'd2, 4'd6, 4'd8};
    localparam logic [3:0] EDGES   [4] = '{4'd1, 4'd3, 4'd5, 4'd7};

    function automatic logic [1:0] cell_at(input logic [17:0] board, input logic [3:0] idx);
        return board[{idx, 1'b0} +: 2];
    endfunction

endpackage

// File: rtl/ttt_line_eval.sv
// Combinational evaluation of one three-cell line: detects a pending win for
// my_side, a pending opponent win to block, and the first empty position.
module ttt_line_eval
    import ttt_pkg::*;
(
    input  logic [1:0] c0_i,
    input  logic [1:0] c1_i,
    input  logic [1:0] c2_i,
    input  logic       my_side_i,
    output logic       is_win_o,
    output logic       is_block_o,
    output logic [1:0] empty_pos_o
);

    logic [5:0] cells;
    logic [1:0] own_code;
    logic [1:0] opp_code;
    logic [1:0] n_own;
    logic [1:0] n_opp;
    logic [1:0] n_emp;
    logic       found;

    assign cells    = {c2_i, c1_i, c0_i};
    assign own_code = my_side_i ? CELL_O : CELL_X;
    assign opp_code = my_side_i ? CELL_X : CELL_O;

    always_comb begin
        n_own       = '0;
        n_opp       = '0;
        n_emp       = '0;
        found       = 1'b0;
        empty_pos_o = '0;
        for (int unsigned k = 0; k < 3; k++) begin
            if (cells[2*k +: 2] == own_code) n_own = n_own + 2'd1;
            if (cells[2*k +: 2] == opp_code) n_opp = n_opp + 2'd1;
            if (cells[2*k +: 2] == CELL_EMPTY) begin
                n_emp = n_emp + 2'd1;
                if (!found) begin
                    empty_pos_o = 2'(k);
                    found       = 1'b1;
                end
            end
        end
        is_win_o   = (n_own == 2'd2) && (n_emp == 2'd1);
        is_block_o = (n_opp == 2'd2) && (n_emp == 2'd1);
    end

endmodule

// File: rtl/ttt_auto_player.sv
// Automated tic-tac-toe opponent: snapshots the board on its turn, scans all
// eight lines, then strobes a move chosen by win/block/centre/corner/edge priority.
module ttt_auto_player
    import ttt_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        my_side,
    input  logic [17:0] board_in,
    input  logic        turn,
    input  logic [1:0]  winner,
    input  logic        invalid_move,
    output logic [3:0]  move_idx,
    output logic        move_en,
    output logic        busy,
    output logic        error
);

    localparam int unsigned WW = $clog2(ACK_TIMEOUT + 1);

    state_e      state_q, state_d;
    logic [2:0]  line_q, line_d;
    logic [17:0] snap_q, snap_d;
    logic        win_vld_q, win_vld_d;
    logic [3:0]  win_cell_q, win_cell_d;
    logic        blk_vld_q, blk_vld_d;
    logic [3:0]  blk_cell_q, blk_cell_d;
    logic [8:0]  empty_q, empty_d;
    logic [WW-1:0] wait_q, wait_d;
    logic [3:0]  move_idx_q, move_idx_d;
    logic        move_en_q, move_en_d;
    logic        busy_q, busy_d;
    logic        error_q, error_d;

    logic [1:0]  lc0, lc1, lc2;
    logic        ev_win, ev_block;
    logic [1:0]  ev_pos;
    logic        has_illegal;
    logic        pick_vld;
    logic [3:0]  pick;

    assign lc0 = cell_at(snap_q, LINES[line_q][0]);
    assign lc1 = cell_at(snap_q, LINES[line_q][1]);
    assign lc2 = cell_at(snap_q, LINES[line_q][2]);

    ttt_line_eval u_line_eval (
        .c0_i        (lc0),
        .c1_i        (lc1),
        .c2_i        (lc2),
        .my_side_i   (my_side),
        .is_win_o    (ev_win),
        .is_block_o  (ev_block),
        .empty_pos_o (ev_pos)
    );

    always_comb begin
        has_illegal = 1'b0;
        for (int unsigned i = 0; i < 9; i++) begin
            if (snap_q[2*i +: 2] == CELL_BAD) has_illegal = 1'b1;
        end
    end

    // Move choice from the values accumulated over the eight scanned lines.
    always_comb begin
        pick_vld = 1'b0;
        pick     = '0;
        if (win_vld_q) begin
            pick_vld = 1'b1;
            pick     = win_cell_q;
        end else if (blk_vld_q) begin
            pick_vld = 1'b1;
            pick     = blk_cell_q;
        end else if (empty_q[4]) begin
            pick_vld = 1'b1;
            pick     = 4'd4;
        end else begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (!pick_vld && empty_q[CORNERS[i]]) begin
                    pick_vld = 1'b1;
                    pick     = CORNERS[i];
                end
            end
            for (int unsigned i = 0; i < 4; i++) begin
                if (!pick_vld && empty_q[EDGES[i]]) begin
                    pick_vld = 1'b1;
                    pick     = EDGES[i];
                end
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        line_d     = line_q;
        snap_d     = snap_q;
        win_vld_d  = win_vld_q;
        win_cell_d = win_cell_q;
        blk_vld_d  = blk_vld_q;
        blk_cell_d = blk_cell_q;
        empty_d    = empty_q;
        wait_d     = wait_q;
        move_idx_d = move_idx_q;
        move_en_d  = 1'b0;
        error_d    = error_q;

        case (state_q)
            IDLE: begin
                if (enable && !error_q && winner == WIN_NONE && turn == my_side) begin
                    state_d   = SCAN;
                    line_d    = '0;
                    snap_d    = board_in;
                    win_vld_d = 1'b0;
                    blk_vld_d = 1'b0;
                    empty_d   = '0;
                end
            end
            SCAN: begin
                if (!enable || winner != WIN_NONE) begin
                    state_d = IDLE;
                end else if (has_illegal) begin
                    error_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    if (ev_win && !win_vld_q) begin
                        win_vld_d  = 1'b1;
                        win_cell_d = LINES[line_q][ev_pos];
                    end
                    if (ev_block && !blk_vld_q) begin
                        blk_vld_d  = 1'b1;
                        blk_cell_d = LINES[line_q][ev_pos];
                    end
                    if (lc0 == CELL_EMPTY) empty_d[LINES[line_q][0]] = 1'b1;
                    if (lc1 == CELL_EMPTY) empty_d[LINES[line_q][1]] = 1'b1;
                    if (lc2 == CELL_EMPTY) empty_d[LINES[line_q][2]] = 1'b1;
                    if (line_q == 3'd7) state_d = DECIDE;
                    else                line_d  = line_q + 3'd1;
                end
            end
            DECIDE: begin
                if (!enable || winner != WIN_NONE) begin
                    state_d = IDLE;
                end else if (!pick_vld) begin
                    error_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    move_idx_d = pick;
                    move_en_d  = 1'b1;
                    wait_d     = '0;
                    state_d    = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (turn != my_side || winner != WIN_NONE) begin
                    state_d = IDLE;
                end else if (invalid_move) begin
                    error_d = 1'b1;
                    state_d = IDLE;
                end else if (wait_q == WW'(ACK_TIMEOUT - 1)) begin
                    error_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            line_q     <= '0;
            snap_q     <= '0;
            win_vld_q  <= 1'b0;
            win_cell_q <= '0;
            blk_vld_q  <= 1'b0;
            blk_cell_q <= '0;
            empty_q    <= '0;
            wait_q     <= '0;
            move_idx_q <= '0;
            move_en_q  <= 1'b0;
            busy_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            line_q     <= line_d;
            snap_q     <= snap_d;
            win_vld_q  <= win_vld_d;
            win_cell_q <= win_cell_d;
            blk_vld_q  <= blk_vld_d;
            blk_cell_q <= blk_cell_d;
            empty_q    <= empty_d;
            wait_q     <= wait_d;
            move_idx_q <= move_idx_d;
            move_en_q  <= move_en_d;
            busy_q     <= busy_d;
            error_q    <= error_d;
        end
    end

    assign move_idx = move_idx_q;
    assign move_en  = move_en_q;
    assign busy     = busy_q;
    assign error    = error_q;

endmodule

// File: tb/tb_ttt_auto_player.sv
// Scoreboard bench for ttt_auto_player: expected moves and trigger cycles are
// queued when a turn is offered and checked when move_en is observed.
module tb_ttt_auto_player;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        my_side;
    logic [17:0] board_in;
    logic        turn;
    logic [1:0]  winner;
    logic        invalid_move;
    logic [3:0]  move_idx;
    logic        move_en;
    logic        busy;
    logic        error;

    typedef struct {
        logic [3:0] idx;
        int         trig;
    } exp_t;

    exp_t exp_q[$];
    int   total   = 0;
    int   bad     = 0;
    int   cyc     = 0;
    int   strobes = 0;

    ttt_auto_player #(.ACK_TIMEOUT(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .my_side      (my_side),
        .board_in     (board_in),
        .turn         (turn),
        .winner       (winner),
        .invalid_move (invalid_move),
        .move_idx     (move_idx),
        .move_en      (move_en),
        .busy         (busy),
        .error        (error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard consumer: every strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && move_en === 1'b1) begin
            exp_t e;
            strobes++;
            check("sb_nonempty", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("move_idx", 32'(move_idx), 32'(e.idx));
                check("strobe_latency", 32'(cyc - e.trig), 9);
            end
        end
    end

    task automatic start(input logic [17:0] b, input logic s, input int exp_idx);
        logic [3:0] ei;
        @(posedge clk);
        #1;
        board_in     = b;
        my_side      = s;
        turn         = s;
        winner       = 2'b00;
        invalid_move = 1'b0;
        enable       = 1'b1;
        if (exp_idx >= 0) begin
            ei = 4'(exp_idx);
            exp_q.push_back('{ei, cyc + 1});
        end
    endtask

    task automatic wait_strobe();
        bit seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (move_en === 1'b1) begin
                seen = 1;
                break;
            end
        end
        check("strobe_seen", 32'(seen), 1);
    endtask

    // Engine accepts the move: flips turn, then the player is parked.
    task automatic accept_move();
        turn = ~my_side;
        @(negedge clk);
        check("move_en_one_cycle", 32'(move_en), 0);
        enable = 1'b0;
        @(negedge clk);
        check("busy_after_ack", 32'(busy), 0);
    endtask

    task automatic do_reset();
        #2;
        enable = 1'b0;
        rst_n  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic play(input logic [17:0] b, input logic s, input int exp_idx);
        start(b, s, exp_idx);
        wait_strobe();
        accept_move();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int snap_strobes;
        bit busy_all;

        rst_n        = 1'b0;
        enable       = 1'b0;
        my_side      = 1'b0;
        board_in     = '0;
        turn         = 1'b0;
        winner       = 2'b00;
        invalid_move = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_move_idx", 32'(move_idx), 0);
        check("rst_move_en", 32'(move_en), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_error", 32'(error), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Empty board: centre, busy held through the whole scan.
        start(18'h00000, 1'b0, 4);
        @(negedge clk);
        busy_all = 1'b1;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            busy_all &= busy;
            if (k < 8) check("no_early_strobe", 32'(move_en), 0);
        end
        check("busy_throughout", 32'(busy_all), 1);
        wait_strobe();
        check("busy_at_strobe", 32'(busy), 1);
        accept_move();
        check("move_idx_holds", 32'(move_idx), 4);

        play(18'h00100, 1'b1, 0);   // centre taken -> first corner
        play(18'h00205, 1'b1, 2);   // block X on row 0
        play(18'h10285, 1'b1, 5);   // own win beats block
        play(18'h00129, 1'b0, 8);   // X wins on diagonal
        play(18'h12121, 1'b1, 1);   // corners + centre full -> first edge

        // Snapshot isolation: board changes after trigger are ignored.
        start(18'h00000, 1'b0, 4);
        repeat (3) @(negedge clk);
        board_in = 18'h00100;
        wait_strobe();
        accept_move();

        // Abort: enable dropped in the 4th scan cycle.
        snap_strobes = strobes;
        start(18'h00000, 1'b0, -1);
        repeat (4) @(posedge clk);
        #1 enable = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("abort_busy_low", 32'(busy), 0);
        repeat (12) @(negedge clk);
        check("abort_no_strobe", 32'(strobes), 32'(snap_strobes));
        check("abort_no_error", 32'(error), 0);

        // Rejected move: error latches, no retry while turn stays ours.
        start(18'h00000, 1'b0, 4);
        wait_strobe();
        invalid_move = 1'b1;
        @(negedge clk);
        invalid_move = 1'b0;
        check("invalid_error", 32'(error), 1);
        check("invalid_idle", 32'(busy), 0);
        snap_strobes = strobes;
        repeat (15) @(negedge clk);
        check("invalid_no_retry", 32'(strobes), 32'(snap_strobes));
        #2 rst_n = 1'b0;
        #1 check("reset_clears_error", 32'(error), 0);
        enable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Ack timeout: turn never flips.
        start(18'h00000, 1'b0, 4);
        wait_strobe();
        repeat (15) @(negedge clk);
        check("timeout_not_yet", 32'(error), 0);
        @(negedge clk);
        check("timeout_error", 32'(error), 1);
        check("timeout_idle", 32'(busy), 0);
        do_reset();

        // Full board: no strobe, error.
        snap_strobes = strobes;
        start(18'h15555, 1'b0, -1);
        repeat (11) @(negedge clk);
        check("full_error", 32'(error), 1);
        check("full_no_strobe", 32'(strobes), 32'(snap_strobes));
        do_reset();

        // Illegal cell code in snapshot.
        start(18'h00003, 1'b0, -1);
        repeat (3) @(negedge clk);
        check("illegal_error", 32'(error), 1);
        check("illegal_idle", 32'(busy), 0);
        do_reset();

        // Asynchronous reset during the strobe cycle.
        start(18'h00000, 1'b0, 4);
        wait_strobe();
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_move_en", 32'(move_en), 0);
        check("async_rst_busy", 32'(busy), 0);
        check("async_rst_move_idx", 32'(move_idx), 0);
        enable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        check("sb_drained", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ttt_auto_player.md
Name: ttt_auto_player

Overview:
- Automated opponent that sits on the move-input side of the `tic_tac_toe` game engine.
- Reads the engine's board, turn and winner outputs; when it is this player's turn, it computes a move and issues a one-cycle `move_en` pulse with `move_idx`.
- Lets a bench or top level play human-vs-machine or machine-vs-machine without scripted move lists.

Parameters:
- ACK_TIMEOUT, 16: cycles to wait in WAIT_ACK for the engine to flip turn before flagging an error.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- enable  input  1  1 = player active; 0 = abort and stay idle
- my_side  input  1  side played: 0 = X, 1 = O
- board_in  input  18  engine board; cell i at bits [2i+1:2i]; 00 empty, 01 X, 10 O, 11 illegal
- turn  input  1  engine side-to-move: 0 = X, 1 = O
- winner  input  2  00 none, 01 X, 10 O, 11 draw
- invalid_move  input  1  engine rejected last move
- move_idx  output  4  chosen cell 0..8
- move_en  output  1  one-cycle move strobe
- busy  output  1  high in any state other than IDLE
- error  output  1  sticky; cleared only by reset

Behaviour:
- Reset (asynchronous, active-low): state = IDLE, move_idx = 0, move_en = 0, busy = 0, error = 0; snapshot and line counter cleared.
- All outputs are registered.
- IDLE:
  - Trigger when enable=1, error=0, winner=00 and turn=my_side.
  - On the trigger edge, snapshot board_in and go to SCAN with line counter = 0.
- SCAN: one line per cycle, 8 cycles, lines from the package table.
  - Win candidate: a line with two own marks and one empty.
  - Block candidate: a line with two opponent marks and one empty.
  - Keep only the first (lowest line number) win and the first block; record each empty cell.
- DECIDE (edge after the last line). Priority:
  1. win cell
  2. block cell
  3. centre 4, if empty
  4. first empty corner in order 0, 2, 6, 8
  5. first empty edge in order 1, 3, 5, 7
  - Registers move_idx, pulses move_en = 1 for exactly one cycle, then goes to WAIT_ACK.
  - move_en rises 9 clock edges after the trigger edge.
  - If no empty cell exists: set error, no strobe, return to IDLE.
- WAIT_ACK: counts cycles.
  - Return to IDLE when turn != my_side or winner != 00.
  - invalid_move = 1 sets error and returns to IDLE.
  - Counter reaching ACK_TIMEOUT sets error and returns to IDLE.
- Abort: enable=0 or winner != 00 during SCAN or DECIDE returns to IDLE on the next edge with no strobe.
- Illegal cell code 11 in the snapshot: set error, return to IDLE.
- Snapshot isolation: board_in changes during SCAN are ignored.
- move_en is never asserted twice for the same turn.
- move_idx holds its last value when idle.
- Asynchronous reset mid-scan or mid-strobe forces move_en to 0 immediately.

Decomposition:
- Package `ttt_pkg`:
  - cell codes CELL_EMPTY / CELL_X / CELL_O
  - winner codes
  - state enum IDLE / SCAN / DECIDE / WAIT_ACK
  - constant LINES[8][3] = {0,1,2}, {3,4,5}, {6,7,8}, {0,3,6}, {1,4,7}, {2,5,8}, {0,4,8}, {2,4,6}
  - corner and edge order tables
- Sub-module `ttt_line_eval`:
  - Combinational; takes three 2-bit cells and my_side.
  - Returns is_win, is_block and empty_pos (0..2).
  - Reused by a future hint or display block.

Test Plan:
- Empty board (18'h00000), my_side=0, turn=0, enable=1 -> single move_en pulse 9 edges after trigger, move_idx=4, busy high throughout.
- X at 4 (18'h00100), my_side=1, turn=1 -> move_idx=0 (first corner).
- X at 0,1 and O at 4 (18'h00205), my_side=1, turn=1 -> move_idx=2 (block).
- X at 0,1,8 and O at 3,4 (18'h10285), my_side=1, turn=1 -> move_idx=5 (win beats block at 2).
- Engine returns invalid_move=1 the cycle after the strobe -> error=1, IDLE, no further move_en even though turn=my_side; rst_n low clears error.
- enable dropped in the 4th SCAN cycle -> no move_en; busy low next cycle. Separately, turn held at my_side after the strobe for 16 cycles -> error=1.
